// File: rtl/pe_pkg.sv
// pe_pkg: shared constants, beat tag type and saturation helper for the
// mac_pe_tagged systolic processing element.
package pe_pkg;

    // Default operand and accumulator widths for the GPU matrix array
    localparam int PE_DATA_W = 16;
    localparam int PE_ACC_W  = 32;

    // Beat framing tag, used for both the forwarded and the pipelined copy
    typedef struct packed {
        logic valid;
        logic clear;
        logic last;
    } pe_tag_t;

    // Outcome of a saturating add: whether to clamp, and toward which bound
    typedef struct packed {
        logic clamp;
        logic high;
    } pe_sat_t;

    // Saturating-add decision from the operand/sum sign bits and the carry.
    // Signed: overflow when both operands share a sign the sum does not.
    // Unsigned: overflow is a carry out; only the upper bound can be hit.
    function automatic pe_sat_t sat_add_check(
        input logic is_signed,
        input logic a_msb,
        input logic b_msb,
        input logic sum_msb,
        input logic carry
    );
        pe_sat_t r;
        if (is_signed) begin
            r.clamp = (a_msb == b_msb) && (sum_msb != a_msb);
            r.high  = ~a_msb;
        end else begin
            r.clamp = carry;
            r.high  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_result_buf.sv
// pe_result_buf: one-entry valid/ready result register. A load while an
// unaccepted result is held overwrites it and sets the sticky overrun flag.
module pe_result_buf
    import pe_pkg::*;
#(
    parameter int ACC_W = PE_ACC_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [ACC_W-1:0] load_data,
    input  logic             load_sat,
    input  logic             ready,
    output logic             valid,
    output logic [ACC_W-1:0] data,
    output logic             sat,
    output logic             overrun
);

    // Entry state: load wins over consumption, so a same-edge load keeps valid high
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is written with non-blocking assignments only,
        // so every flop samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            valid   <= 1'b0;
            data    <= '0;
            sat     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                data  <= load_data;
                sat   <= load_sat;
                if (valid && !ready) begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mac_pe_tagged.sv
// mac_pe_tagged: systolic multiply-accumulate processing element.
// Forwards A east / B south with one cycle of latency, runs a two-stage
// multiply/accumulate pipeline framed by clear/last tags, and hands completed
// dot products to a one-entry valid/ready buffer. en=0 stalls the array.
// Optional feature macro: MAC_PE_SAT_EN (saturating accumulation, res_sat).
module mac_pe_tagged
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int ACC_W  = PE_ACC_W,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_clear,
    input  logic              in_last,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_clear,
    output logic              out_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_sat,
    output logic              res_overrun
);

    localparam int PROD_W = 2 * DATA_W;

    // The accumulator must hold a full product without loss
    if (ACC_W < PROD_W) begin : g_bad_width
        $error("mac_pe_tagged: ACC_W (%0d) must be >= 2*DATA_W (%0d)", ACC_W, PROD_W);
    end

    pe_tag_t          in_tag;
    pe_tag_t          fwd_tag;
    pe_tag_t          s1_tag;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] p_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic             res_load;
    logic             res_sat_in;

    assign in_tag = '{valid: in_valid, clear: in_clear, last: in_last};

    // Product extended to the accumulator width according to signedness
    if (SIGNED != 0) begin : g_mul_signed
        logic signed [PROD_W-1:0] a_s;
        logic signed [PROD_W-1:0] b_s;
        logic signed [PROD_W-1:0] prod_s;
        assign a_s      = PROD_W'($signed(in_a));
        assign b_s      = PROD_W'($signed(in_b));
        assign prod_s   = a_s * b_s;
        assign prod_ext = ACC_W'(prod_s);
    end else begin : g_mul_unsigned
        logic [PROD_W-1:0] prod_u;
        assign prod_u   = PROD_W'(in_a) * PROD_W'(in_b);
        assign prod_ext = ACC_W'(prod_u);
    end

    // Forwarding registers: pass every beat east/south, hold while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_tag <= '0;
            out_a   <= '0;
            out_b   <= '0;
        end else if (en) begin
            fwd_tag <= in_tag;
            out_a   <= in_a;
            out_b   <= in_b;
        end
    end

    assign out_valid = fwd_tag.valid;
    assign out_clear = fwd_tag.clear;
    assign out_last  = fwd_tag.last;

    // Stage 1: register the product and its tag; idle beats carry a null tag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_tag <= '0;
            p_q    <= '0;
        end else if (en) begin
            s1_tag <= in_valid ? in_tag : '0;
            if (in_valid) begin
                p_q <= prod_ext;
            end
        end
    end

`ifdef MAC_PE_SAT_EN
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_max;
    logic [ACC_W-1:0] acc_min;
    logic             sat_flag;
    logic             sat_next;
    pe_sat_t          ovf;

    assign sum_wide = {1'b0, acc} + {1'b0, p_q};
    assign acc_max  = (SIGNED != 0) ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
    assign acc_min  = (SIGNED != 0) ? {1'b1, {(ACC_W-1){1'b0}}} : '0;
    assign ovf      = sat_add_check(SIGNED != 0, acc[ACC_W-1], p_q[ACC_W-1],
                                    sum_wide[ACC_W-1], sum_wide[ACC_W]);

    // Stage 2 next value: restart on clear, otherwise clamp-or-add
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        acc_next = sum_wide[ACC_W-1:0];
        sat_next = sat_flag;
        if (s1_tag.clear) begin
            acc_next = p_q;
            sat_next = 1'b0;
        end else if (ovf.clamp) begin
            acc_next = ovf.high ? acc_max : acc_min;
            sat_next = 1'b1;
        end
    end

    // Per-tile sticky saturation flag, advancing with the accumulator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_flag <= 1'b0;
        end else if (en && s1_tag.valid) begin
            sat_flag <= sat_next;
        end
    end

    assign res_sat_in = sat_next;
`else
    logic [ACC_W-1:0] sum_wrap;

    assign sum_wrap = acc + p_q;

    // Stage 2 next value: restart on clear, otherwise wrap-around add
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        acc_next = sum_wrap;
        if (s1_tag.clear) begin
            acc_next = p_q;
        end
    end

    assign res_sat_in = 1'b0;
`endif

    // Stage 2: accumulator advances only on valid beats while not stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (en && s1_tag.valid) begin
            acc <= acc_next;
        end
    end

    // The closing beat of a tile hands the same next-acc value to the buffer
    assign res_load = en && s1_tag.valid && s1_tag.last;

    pe_result_buf #(
        .ACC_W (ACC_W)
    ) u_res_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (res_load),
        .load_data (acc_next),
        .load_sat  (res_sat_in),
        .ready     (res_ready),
        .valid     (res_valid),
        .data      (res_data),
        .sat       (res_sat),
        .overrun   (res_overrun)
    );

endmodule

// File: tb/tb_mac_pe_tagged.sv
// tb_mac_pe_tagged: directed self-checking bench for mac_pe_tagged.
// An unsigned and a signed instance share all inputs; each vector checks the
// instance whose behaviour it targets. MAC_PE_SAT_EN selects saturation checks.
module tb_mac_pe_tagged;

    localparam int DW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic          in_valid;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_clear;
    logic          in_last;
    logic          res_ready;

    logic          u_out_valid, u_out_clear, u_out_last;
    logic [DW-1:0] u_out_a, u_out_b;
    logic          u_res_valid, u_res_sat, u_res_overrun;
    logic [AW-1:0] u_res_data;

    logic          s_out_valid, s_out_clear, s_out_last;
    logic [DW-1:0] s_out_a, s_out_b;
    logic          s_res_valid, s_res_sat, s_res_overrun;
    logic [AW-1:0] s_res_data;

    int n_vec     = 0;
    int n_miscomp = 0;

    mac_pe_tagged #(.DATA_W(DW), .ACC_W(AW), .SIGNED(0)) dut_u (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_clear    (in_clear),
        .in_last     (in_last),
        .out_valid   (u_out_valid),
        .out_a       (u_out_a),
        .out_b       (u_out_b),
        .out_clear   (u_out_clear),
        .out_last    (u_out_last),
        .res_valid   (u_res_valid),
        .res_ready   (res_ready),
        .res_data    (u_res_data),
        .res_sat     (u_res_sat),
        .res_overrun (u_res_overrun)
    );

    mac_pe_tagged #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1)) dut_s (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_clear    (in_clear),
        .in_last     (in_last),
        .out_valid   (s_out_valid),
        .out_a       (s_out_a),
        .out_b       (s_out_b),
        .out_clear   (s_out_clear),
        .out_last    (s_out_last),
        .res_valid   (s_res_valid),
        .res_ready   (res_ready),
        .res_data    (s_res_data),
        .res_sat     (s_res_sat),
        .res_overrun (s_res_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscomp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic c, input logic l);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_clear = c;
        in_last  = l;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_clear = 1'b0;
        in_last  = 1'b0;
        step();
    endtask

    // Watchdog: the directed sequence is short; anything longer is a hang
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        en        = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_clear  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        #12;
        check("rst_out_valid", u_out_valid, 0);
        check("rst_out_a",     u_out_a,     0);
        check("rst_res_valid", u_res_valid, 0);
        check("rst_res_data",  u_res_data,  0);
        check("rst_overrun",   u_res_overrun, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // 1: unsigned 4-beat tile 1*5+2*6+3*7+4*8 = 70, A forwarded one cycle late
        beat(16'd1, 16'd5, 1'b1, 1'b0);
        check("t1_out_a0",     u_out_a, 1);
        check("t1_out_valid",  u_out_valid, 1);
        check("t1_out_clear",  u_out_clear, 1);
        beat(16'd2, 16'd6, 1'b0, 1'b0);
        check("t1_out_a1",     u_out_a, 2);
        check("t1_out_clear1", u_out_clear, 0);
        beat(16'd3, 16'd7, 1'b0, 1'b0);
        check("t1_out_a2",     u_out_a, 3);
        beat(16'd4, 16'd8, 1'b0, 1'b1);
        check("t1_out_a3",     u_out_a, 4);
        check("t1_out_b3",     u_out_b, 8);
        check("t1_out_last",   u_out_last, 1);
        check("t1_not_yet",    u_res_valid, 0);
        idle();
        check("t1_res_valid",  u_res_valid, 1);
        check("t1_res_data",   u_res_data, 70);
        check("t1_res_sat",    u_res_sat, 0);
        check("t1_fwd_idle",   u_out_valid, 0);
        idle();
        check("t1_consumed",   u_res_valid, 0);

        // 2: single clear+last beat 0xFFFF*3, signed -3 vs unsigned 0x2FFFD
        beat(16'hFFFF, 16'd3, 1'b1, 1'b1);
        idle();
        check("t2_s_valid",    s_res_valid, 1);
        check("t2_s_data",     s_res_data, 32'hFFFF_FFFD);
        check("t2_u_data",     u_res_data, 32'h0002_FFFD);
        idle();

        // 3: back-to-back tiles with no consumer: 26 overwritten by 50
        res_ready = 1'b0;
        beat(16'd2, 16'd3, 1'b1, 1'b0);
        beat(16'd4, 16'd5, 1'b0, 1'b1);
        beat(16'd1, 16'd1, 1'b1, 1'b0);
        check("t3_first_data", u_res_data, 26);
        check("t3_first_ovr",  u_res_overrun, 0);
        beat(16'd7, 16'd7, 1'b0, 1'b1);
        check("t3_held_data",  u_res_data, 26);
        idle();
        check("t3_valid",      u_res_valid, 1);
        check("t3_second",     u_res_data, 50);
        check("t3_overrun",    u_res_overrun, 1);
        res_ready = 1'b1;
        idle();
        check("t3_drained",    u_res_valid, 0);
        check("t3_ovr_sticky", u_res_overrun, 1);

        // 4: 3-cycle stall mid-tile with live beats; result 12+30+20 = 62
        beat(16'd3, 16'd4, 1'b1, 1'b0);
        beat(16'd5, 16'd6, 1'b0, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = DW'(9 - i);
            in_b     = DW'(9 - i);
            in_clear = (i == 0);
            in_last  = (i == 2);
            step();
            check("t4_stall_a",  u_out_a, 5);
            check("t4_stall_b",  u_out_b, 6);
            check("t4_stall_rv", u_res_valid, 0);
        end
        en = 1'b1;
        beat(16'd10, 16'd2, 1'b0, 1'b1);
        check("t4_resume_a",   u_out_a, 10);
        idle();
        check("t4_res_valid",  u_res_valid, 1);
        check("t4_res_data",   u_res_data, 62);
        en = 1'b0;
        idle();
        check("t4_drain_stall", u_res_valid, 0);
        en = 1'b1;

        // 5: asynchronous reset mid-tile, then a tile with no clear: 2*3 = 6
        beat(16'd4, 16'd4, 1'b1, 1'b0);
        beat(16'd5, 16'd5, 1'b0, 1'b0);
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_out_valid",  u_out_valid, 0);
        check("t5_out_a",      u_out_a, 0);
        check("t5_res_data",   u_res_data, 0);
        check("t5_overrun",    u_res_overrun, 0);
        @(negedge clk);
        reset_n = 1'b1;
        beat(16'd2, 16'd3, 1'b0, 1'b1);
        idle();
        check("t5_res_valid",  u_res_valid, 1);
        check("t5_res_data6",  u_res_data, 6);
        idle();

        // 6: three 0x7FFF*0x7FFF beats (3*0x3FFF0001), then a 1*1 tile
        beat(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        beat(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        beat(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
        idle();
`ifdef MAC_PE_SAT_EN
        check("t6_s_data",     s_res_data, 32'h7FFF_FFFF);
        check("t6_s_sat",      s_res_sat, 1);
`else
        check("t6_s_data",     s_res_data, 32'hBFFD_0003);
        check("t6_s_sat",      s_res_sat, 0);
`endif
        check("t6_u_data",     u_res_data, 32'hBFFD_0003);
        check("t6_u_sat",      u_res_sat, 0);
        beat(16'd1, 16'd1, 1'b1, 1'b1);
        idle();
        check("t6_next_data",  s_res_data, 1);
        check("t6_next_sat",   s_res_sat, 0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end

endmodule
